or_share_arbiter: RTL and testbench
===================================

OR_SHARE_ARBITER -- requirements
Module: or_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, operand/result width in bits (1..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept strobe, at most one bit high.
REQ-007 SHALL have port req_a  input  N_REQ*W  packed operand A; requester i at bits [i*W +: W].
REQ-008 SHALL have port req_b  input  N_REQ*W  packed operand B, same packing.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-012 SHALL have port rsp_y  output  W  result, bitwise OR of captured operands.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid bit set, SHALL grant exactly one requester, assert its req_ready combinationally that cycle, capture its a, b and index, and go to EXEC.
REQ-016 Grant SHALL be round-robin: search starts at ptr and wraps N_REQ-1 -> 0; first set req_valid bit wins.
REQ-017 IDLE with no req_valid SHALL keep req_ready all-zero and stay in IDLE.
REQ-018 EXEC: SHALL register rsp_y = a_cap | b_cap and rsp_id = granted index, then go to RESP (one cycle).
REQ-019 RESP: rsp_valid SHALL be high; rsp_y and rsp_id SHALL be held stable until rsp_ready is high.
REQ-020 RESP with rsp_ready high SHALL complete the transfer, set ptr = (granted index + 1) mod N_REQ, and return to IDLE.
REQ-021 Latency: acceptance in cycle T SHALL give rsp_valid in cycle T+2; minimum spacing between acceptances is 3 cycles.
REQ-022 req_ready SHALL be zero in EXEC and RESP; requests then are not consumed.
REQ-023 A requester deasserting req_valid before being granted SHALL be dropped with no side effect.
REQ-024 Operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 With all requesters continuously valid, each SHALL be granted exactly once per N_REQ grants.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_y 0, busy 0.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is issued for it.
REQ-028 After rst_n deassertion, the first grant SHALL occur no earlier than the next rising edge.

Structure
REQ-029 FSM state encoding and the clog2 index-width helper SHALL live in shared package or_share_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: one-hot grant, index, any).
REQ-031 Datapath SHALL be one W-bit OR stage plus capture/result registers; no other arithmetic.

Verification
REQ-032 Reset: hold rst_n low mid-RESP with rsp_ready=0 -> rsp_valid, busy, req_ready drop to 0 immediately; no response after release.
REQ-033 Single op: req_valid=0001, a0=8'hA0, b0=8'h05, rsp_ready=1 -> req_ready=0001 at T, rsp_valid at T+2 with rsp_y=8'hA5, rsp_id=0.
REQ-034 Fairness: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,1,... with rsp_id following same order.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP, operands changed meanwhile -> rsp_y/rsp_id constant, no new req_ready until handshake.
REQ-036 Wrap/skip: ptr=3, req_valid=0101 -> requester 0 granted, ptr becomes 1; next grant goes to requester 2.
REQ-037 Withdrawal: requester 1 raises then drops req_valid while busy -> never granted, no rsp_id=1 emitted.

Source files
------------

// File: rtl/or_share_pkg.sv
// Shared FSM encoding and index-width helper for the OR-share arbiter.
package or_share_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/or_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rot;
  int unsigned  pos;
  int unsigned  sum;

  // Rotate so ptr lands at bit 0, take lowest set bit, then rotate the index back.
  always_comb begin
    rot = N'({req, req} >> ptr);
    pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rot[N-1-k]) pos = N - 1 - k;
    end
    sum = int'(ptr) + pos;
    if (sum >= N) sum = sum - N;
    any = |req;
    idx = any ? IW'(sum) : '0;
    gnt = any ? (N'(1) << sum) : '0;
  end

endmodule

// File: rtl/or_share_arbiter.sv
// Round-robin shared OR unit: grant one requester, compute a|b, hold result until taken.
module or_share_arbiter
  import or_share_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned IW    = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [W-1:0]       rsp_y,
  output logic               busy
);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     rsp_y_q, rsp_y_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          a_d     = req_a[pick_idx*W +: W];
          b_d     = req_b[pick_idx*W +: W];
          id_d    = pick_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_y_d  = a_q | b_q;
        rsp_id_d = id_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // Grant is gated by rst_n so nothing is offered while reset is held.
  assign req_ready = (rst_n && state_q == ST_IDLE) ? pick_gnt : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_or_share_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed literal checks.
module tb_or_share_arbiter;

  localparam int NQ = 4;
  localparam int WD = 8;

  logic          clk;
  logic          rst_n;
  logic [NQ-1:0] req_valid;
  logic [NQ-1:0] req_ready;
  logic [NQ*WD-1:0] req_a;
  logic [NQ*WD-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [WD-1:0] rsp_y;
  logic          busy;

  int checks = 0;
  int errors = 0;

  or_share_arbiter #(
    .N_REQ (NQ),
    .W     (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Reference model: one operation in flight, response two cycles after acceptance.
  int unsigned cyc = 0;
  int unsigned m_ptr = 0;
  int unsigned m_id = 0;
  int unsigned m_acc = 0;
  bit          m_busy = 0;
  logic [WD-1:0] m_y = '0;
  int unsigned gnt_log[$];
  int unsigned rsp_id_log[$];
  logic [WD-1:0] rsp_y_log[$];

  always @(negedge clk) begin
    logic [NQ-1:0] exp_rdy;
    bit            exp_rv;
    bit            found;
    int unsigned   g;
    int unsigned   pi;
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_y", rsp_y, 0);
    end else begin
      exp_rdy = '0;
      found   = 0;
      g       = 0;
      if (!m_busy) begin
        for (int off = 0; off < NQ; off++) begin
          pi = (m_ptr + off) % NQ;
          if (!found && req_valid[pi]) begin
            found = 1;
            g     = pi;
            exp_rdy[pi] = 1'b1;
          end
        end
      end
      exp_rv = m_busy && (cyc - m_acc >= 2);
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("busy", busy, m_busy);
      if (exp_rv) begin
        chk("rsp_y", rsp_y, m_y);
        chk("rsp_id", rsp_id, m_id);
      end
      if (found) begin
        m_busy = 1;
        m_acc  = cyc;
        m_id   = g;
        m_y    = req_a[g*WD +: WD] | req_b[g*WD +: WD];
        gnt_log.push_back(g);
      end else if (exp_rv && rsp_ready) begin
        rsp_id_log.push_back(m_id);
        rsp_y_log.push_back(m_y);
        m_ptr  = (m_id + 1) % NQ;
        m_busy = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int unsigned n, input string name);
    int budget = 100;
    while (gnt_log.size() < n && budget > 0) begin
      req_a = $urandom;
      req_b = $urandom;
      step(1);
      budget--;
    end
    if (gnt_log.size() < n) timeout_fail(name);
  endtask

  task automatic wait_rsp_valid(input string name);
    int budget = 20;
    while (!rsp_valid && budget > 0) begin
      step(1);
      budget--;
    end
    if (!rsp_valid) timeout_fail(name);
  endtask

  task automatic drain(input string name);
    int budget = 50;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (m_busy && budget > 0) begin
      step(1);
      budget--;
    end
    if (m_busy) timeout_fail(name);
    step(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned base;
    int unsigned rbase;
    int unsigned cnt;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Single op with literal expectations
    req_valid = 4'b0001;
    req_a[7:0] = 8'hA0;
    req_b[7:0] = 8'h05;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    req_a = $urandom;
    req_b = $urandom;
    @(negedge clk);
    chk("single_exec_rv", rsp_valid, 0);
    @(negedge clk);
    chk("single_rv", rsp_valid, 1);
    chk("single_y", rsp_y, 8'hA5);
    chk("single_id", rsp_id, 0);
    step(1);
    drain("single_drain");

    // Fairness from ptr 0
    do_reset();
    base  = gnt_log.size();
    rbase = rsp_id_log.size();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    wait_grants(base + 8, "fair_wait");
    drain("fair_drain");
    for (int k = 0; k < 8; k++) begin
      if (base + k < gnt_log.size()) chk("fair_gnt", gnt_log[base+k], k % NQ);
      else timeout_fail("fair_gnt_missing");
      if (rbase + k < rsp_id_log.size()) chk("fair_rsp_id", rsp_id_log[rbase+k], k % NQ);
      else timeout_fail("fair_rsp_missing");
    end

    // Backpressure with operand churn
    req_valid = 4'b0100;
    req_a[23:16] = 8'h3C;
    req_b[23:16] = 8'h41;
    rsp_ready = 1'b0;
    step(1);
    wait_rsp_valid("bp_wait");
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      req_a = $urandom;
      req_b = $urandom;
      @(negedge clk);
      chk("bp_y", rsp_y, 8'h7D);
      chk("bp_id", rsp_id, 2);
      chk("bp_ready", req_ready, 0);
      chk("bp_rv", rsp_valid, 1);
      step(1);
    end

    // Wrap/skip: ptr is 3 after requester 2 completes
    base = gnt_log.size();
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    wait_grants(base + 2, "wrap_wait");
    req_valid = '0;
    drain("wrap_drain");
    if (base + 1 < gnt_log.size()) begin
      chk("wrap_first", gnt_log[base], 0);
      chk("wrap_second", gnt_log[base+1], 2);
    end else timeout_fail("wrap_missing");

    // Withdrawal of requester 1 while busy
    base  = gnt_log.size();
    rbase = rsp_id_log.size();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    step(1);
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b0000;
    step(10);
    cnt = 0;
    for (int unsigned k = base; k < gnt_log.size(); k++) if (gnt_log[k] == 1) cnt++;
    for (int unsigned k = rbase; k < rsp_id_log.size(); k++) if (rsp_id_log[k] == 1) cnt++;
    chk("withdraw_id1", cnt, 0);
    chk("withdraw_ops", gnt_log.size() - base, 1);

    // Reset in the middle of RESP
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step(1);
    wait_rsp_valid("rstmid_wait");
    rbase = rsp_id_log.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rv", rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", req_ready, 0);
    rsp_ready = 1'b1;
    step(2);
    req_valid = '0;
    rst_n = 1'b1;
    step(5);
    chk("rstmid_no_rsp", rsp_id_log.size() - rbase, 0);
    chk("rstmid_idle", busy, 0);

    // Randomised traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      req_valid = NQ'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step(1);
    end
    rst_n = 1'b1;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
